// File: rtl/display_source_arbiter_pkg.sv
// Shared encodings for the money-display arbiter: FSM states, source codes,
// the default clamp ceiling and the clamp helper.
package display_source_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHOW_BET = 2'd1,
        ST_SHOW_EVT = 2'd2
    } arb_state_t;

    localparam logic [1:0] SRC_BAL = 2'd0;
    localparam logic [1:0] SRC_BET = 2'd1;
    localparam logic [1:0] SRC_EVT = 2'd2;

    localparam int MAX_VAL_DEF = 10000;

    function automatic logic [15:0] clamp_val(input logic [15:0] v, input logic [15:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/display_source_arbiter_ms_tick_gen.sv
// Millisecond tick prescaler: counts 0..TICK_DIV-1 and flags the last count.
// Held at zero while clr is high, so an overlay always starts on a fresh ms.
module display_source_arbiter_ms_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Free-running modulo-TICK_DIV counter with synchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_cnt == LAST) begin
            r_cnt <= {CW{1'b0}};
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Left ungated by clr: the arbiter's acceptance logic already overrides a coincident tick.
    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/display_source_arbiter.sv
// Owns the 5-digit money display: live balance by default, with timed
// bet and (optionally blinking) event overlays. Priority EVT > BET > BAL.
module display_source_arbiter
    import display_source_arbiter_pkg::*;
#(
    parameter int TICK_DIV    = 100000,
    parameter int BET_HOLD_MS = 1500,
    parameter int EVT_HOLD_MS = 3000,
    parameter int BLINK_MS    = 250,
    parameter int MAX_VAL     = MAX_VAL_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_balance,
    input  logic        i_bet_req,
    input  logic [15:0] i_bet_val,
    output logic        o_bet_ack,
    input  logic        i_evt_req,
    input  logic [15:0] i_evt_val,
    input  logic        i_evt_blink,
    output logic        o_evt_ack,
    output logic [15:0] o_disp_val,
    output logic        o_disp_blank,
    output logic [1:0]  o_disp_src
);

    localparam logic [15:0] MAX_V      = 16'(MAX_VAL);
    localparam logic [15:0] BET_HOLD   = 16'(BET_HOLD_MS);
    localparam logic [15:0] EVT_HOLD   = 16'(EVT_HOLD_MS);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_MS - 1);

    arb_state_t  r_state;
    arb_state_t  w_nxt_state;
    logic        w_acc_bet;
    logic        w_acc_evt;
    logic        w_tick;
    logic        w_clr;
    logic        w_expire;

    logic [15:0] r_disp_val;
    logic [1:0]  r_disp_src;
    logic        r_disp_blank;
    logic        r_bet_ack;
    logic        r_evt_ack;
    logic        r_blink_en;
    logic [15:0] r_hold;
    logic [15:0] r_blink_cnt;

    logic [15:0] w_nxt_val;
    logic [1:0]  w_nxt_src;
    logic        w_nxt_blank;
    logic        w_nxt_blink_en;
    logic [15:0] w_nxt_hold;
    logic [15:0] w_nxt_blink_cnt;

    assign w_clr    = (r_state == ST_IDLE) || w_acc_bet || w_acc_evt;
    assign w_expire = w_tick && (r_hold == 16'd1);

    display_source_arbiter_ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .o_tick  (w_tick)
    );

    // Next-state and acceptance decision; requests are evaluated every cycle.
    always_comb begin
        w_nxt_state = r_state;
        w_acc_bet   = 1'b0;
        w_acc_evt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_evt_req) begin
                    w_nxt_state = ST_SHOW_EVT;
                    w_acc_evt   = 1'b1;
                end else if (i_bet_req) begin
                    w_nxt_state = ST_SHOW_BET;
                    w_acc_bet   = 1'b1;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_SHOW_BET: begin
                if (i_evt_req) begin
                    w_nxt_state = ST_SHOW_EVT;
                    w_acc_evt   = 1'b1;
                end else if (i_bet_req) begin
                    w_nxt_state = ST_SHOW_BET;
                    w_acc_bet   = 1'b1;
                end else if (w_expire) begin
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_nxt_state = ST_SHOW_BET;
                end
            end
            ST_SHOW_EVT: begin
                if (i_evt_req) begin
                    w_nxt_state = ST_SHOW_EVT;
                    w_acc_evt   = 1'b1;
                end else if (w_expire) begin
                    if (i_bet_req) begin
                        w_nxt_state = ST_SHOW_BET;
                        w_acc_bet   = 1'b1;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end else begin
                    w_nxt_state = ST_SHOW_EVT;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: latch on acceptance, track balance in idle, count down otherwise.
    always_comb begin
        w_nxt_val       = r_disp_val;
        w_nxt_src       = r_disp_src;
        w_nxt_blank     = r_disp_blank;
        w_nxt_blink_en  = r_blink_en;
        w_nxt_hold      = r_hold;
        w_nxt_blink_cnt = r_blink_cnt;
        if (w_acc_evt) begin
            w_nxt_val       = clamp_val(i_evt_val, MAX_V);
            w_nxt_src       = SRC_EVT;
            w_nxt_blank     = 1'b0;
            w_nxt_blink_en  = i_evt_blink;
            w_nxt_hold      = EVT_HOLD;
            w_nxt_blink_cnt = 16'd0;
        end else if (w_acc_bet) begin
            w_nxt_val       = clamp_val(i_bet_val, MAX_V);
            w_nxt_src       = SRC_BET;
            w_nxt_blank     = 1'b0;
            w_nxt_blink_en  = 1'b0;
            w_nxt_hold      = BET_HOLD;
            w_nxt_blink_cnt = 16'd0;
        end else if (w_nxt_state == ST_IDLE) begin
            w_nxt_val       = clamp_val(i_balance, MAX_V);
            w_nxt_src       = SRC_BAL;
            w_nxt_blank     = 1'b0;
            w_nxt_blink_en  = 1'b0;
            w_nxt_hold      = 16'd0;
            w_nxt_blink_cnt = 16'd0;
        end else if (w_tick) begin
            w_nxt_hold = r_hold - 16'd1;
            if ((r_state == ST_SHOW_EVT) && r_blink_en) begin
                if (r_blink_cnt == BLINK_LAST) begin
                    w_nxt_blank     = ~r_disp_blank;
                    w_nxt_blink_cnt = 16'd0;
                end else begin
                    w_nxt_blink_cnt = r_blink_cnt + 16'd1;
                end
            end else begin
                w_nxt_blink_cnt = r_blink_cnt;
            end
        end else begin
            w_nxt_hold = r_hold;
        end
    end

    // State and output registers; acks are single-cycle by construction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_disp_val   <= 16'd0;
            r_disp_src   <= SRC_BAL;
            r_disp_blank <= 1'b0;
            r_bet_ack    <= 1'b0;
            r_evt_ack    <= 1'b0;
            r_blink_en   <= 1'b0;
            r_hold       <= 16'd0;
            r_blink_cnt  <= 16'd0;
        end else begin
            r_state      <= w_nxt_state;
            r_disp_val   <= w_nxt_val;
            r_disp_src   <= w_nxt_src;
            r_disp_blank <= w_nxt_blank;
            r_bet_ack    <= w_acc_bet;
            r_evt_ack    <= w_acc_evt;
            r_blink_en   <= w_nxt_blink_en;
            r_hold       <= w_nxt_hold;
            r_blink_cnt  <= w_nxt_blink_cnt;
        end
    end

    assign o_disp_val   = r_disp_val;
    assign o_disp_src   = r_disp_src;
    assign o_disp_blank = r_disp_blank;
    assign o_bet_ack    = r_bet_ack;
    assign o_evt_ack    = r_evt_ack;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter with shortened timing
// (4 clk per ms, bet 3 ms, event 5 ms, blink 2 ms).
module tb_display_source_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] balance;
    logic        bet_req;
    logic [15:0] bet_val;
    logic        bet_ack;
    logic        evt_req;
    logic [15:0] evt_val;
    logic        evt_blink;
    logic        evt_ack;
    logic [15:0] disp_val;
    logic        disp_blank;
    logic [1:0]  disp_src;

    int n_cmp = 0;
    int n_err = 0;

    display_source_arbiter #(
        .TICK_DIV    (4),
        .BET_HOLD_MS (3),
        .EVT_HOLD_MS (5),
        .BLINK_MS    (2),
        .MAX_VAL     (10000)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_balance    (balance),
        .i_bet_req    (bet_req),
        .i_bet_val    (bet_val),
        .o_bet_ack    (bet_ack),
        .i_evt_req    (evt_req),
        .i_evt_val    (evt_val),
        .i_evt_blink  (evt_blink),
        .o_evt_ack    (evt_ack),
        .o_disp_val   (disp_val),
        .o_disp_blank (disp_blank),
        .o_disp_src   (disp_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Walk an overlay from its current cycle until the source changes, recording what was shown.
    task automatic run_overlay(input logic [1:0] src, output int cyc, output int n_bet,
                               output int n_evt, output logic [63:0] blanks, output int n_chg);
        logic [15:0] v0;
        v0     = disp_val;
        cyc    = 0;
        n_bet  = 0;
        n_evt  = 0;
        n_chg  = 0;
        blanks = 64'd0;
        while ((disp_src == src) && (cyc < 100)) begin
            if (cyc < 64) blanks[cyc] = disp_blank;
            if (bet_ack) n_bet++;
            if (evt_ack) n_evt++;
            if (disp_val != v0) n_chg++;
            cyc++;
            step(1);
        end
    endtask

    int          cyc;
    int          nb;
    int          ne;
    int          nc;
    logic [63:0] bl;

    initial begin
        rst_n     = 1'b0;
        balance   = 16'd1234;
        bet_req   = 1'b0;
        bet_val   = 16'd0;
        evt_req   = 1'b0;
        evt_val   = 16'd0;
        evt_blink = 1'b0;

        // 1: reset and balance tracking with clamp
        step(3);
        check_eq("rst_val", 64'(disp_val), 64'd0);
        check_eq("rst_src", 64'(disp_src), 64'd0);
        check_eq("rst_acks", {62'd0, bet_ack, evt_ack}, 64'd0);
        rst_n = 1'b1;
        step(1);
        check_eq("bal_val", 64'(disp_val), 64'd1234);
        check_eq("bal_src", 64'(disp_src), 64'd0);
        balance = 16'd20000;
        step(1);
        check_eq("bal_clamp", 64'(disp_val), 64'd10000);
        balance = 16'd4321;
        step(1);
        check_eq("bal_follow", 64'(disp_val), 64'd4321);

        // 2: simple bet overlay, 12 cycles
        bet_val = 16'd500;
        bet_req = 1'b1;
        step(1);
        bet_req = 1'b0;
        check_eq("t2_ack", 64'(bet_ack), 64'd1);
        check_eq("t2_src", 64'(disp_src), 64'd1);
        check_eq("t2_val", 64'(disp_val), 64'd500);
        run_overlay(2'd1, cyc, nb, ne, bl, nc);
        check_eq("t2_len", 64'(cyc), 64'd12);
        check_eq("t2_ackcnt", 64'(nb), 64'd1);
        check_eq("t2_valchg", 64'(nc), 64'd0);
        check_eq("t2_back_src", 64'(disp_src), 64'd0);
        check_eq("t2_back_val", 64'(disp_val), 64'd4321);
        step(2);

        // 3: simultaneous event (blink) and bet; bet waits for event to end
        evt_val   = 16'd9000;
        evt_blink = 1'b1;
        evt_req   = 1'b1;
        bet_val   = 16'd300;
        bet_req   = 1'b1;
        step(1);
        evt_req = 1'b0;
        check_eq("t3_evt_ack", 64'(evt_ack), 64'd1);
        check_eq("t3_bet_noack", 64'(bet_ack), 64'd0);
        check_eq("t3_src", 64'(disp_src), 64'd2);
        check_eq("t3_val", 64'(disp_val), 64'd9000);
        run_overlay(2'd2, cyc, nb, ne, bl, nc);
        check_eq("t3_len", 64'(cyc), 64'd20);
        check_eq("t3_betack_during", 64'(nb), 64'd0);
        check_eq("t3_blink", bl, 64'h0000_0000_0000_FF00);
        check_eq("t3_bet_ack", 64'(bet_ack), 64'd1);
        check_eq("t3_bet_src", 64'(disp_src), 64'd1);
        check_eq("t3_bet_val", 64'(disp_val), 64'd300);
        check_eq("t3_bet_blank", 64'(disp_blank), 64'd0);
        bet_req   = 1'b0;
        evt_blink = 1'b0;
        run_overlay(2'd1, cyc, nb, ne, bl, nc);
        check_eq("t3_bet_len", 64'(cyc), 64'd12);
        check_eq("t3_idle", 64'(disp_src), 64'd0);
        step(2);

        // 4: event preempts bet 4 cycles in; bet is dropped
        bet_val = 16'd250;
        bet_req = 1'b1;
        step(1);
        bet_req = 1'b0;
        step(3);
        check_eq("t4_bet_still", 64'(disp_src), 64'd1);
        evt_val = 16'd700;
        evt_req = 1'b1;
        step(1);
        evt_req = 1'b0;
        check_eq("t4_src", 64'(disp_src), 64'd2);
        check_eq("t4_val", 64'(disp_val), 64'd700);
        check_eq("t4_ack", 64'(evt_ack), 64'd1);
        run_overlay(2'd2, cyc, nb, ne, bl, nc);
        check_eq("t4_len", 64'(cyc), 64'd20);
        check_eq("t4_noblink", bl, 64'd0);
        check_eq("t4_no_resume", 64'(disp_src), 64'd0);
        check_eq("t4_bal", 64'(disp_val), 64'd4321);
        step(2);

        // 5: bet re-issued mid-overlay restarts the hold
        bet_val = 16'd600;
        bet_req = 1'b1;
        step(1);
        bet_req = 1'b0;
        step(4);
        bet_val = 16'd800;
        bet_req = 1'b1;
        step(1);
        bet_req = 1'b0;
        check_eq("t5_ack", 64'(bet_ack), 64'd1);
        check_eq("t5_val", 64'(disp_val), 64'd800);
        run_overlay(2'd1, cyc, nb, ne, bl, nc);
        check_eq("t5_len", 64'(cyc), 64'd12);
        check_eq("t5_idle", 64'(disp_src), 64'd0);
        step(2);

        // 6: async reset mid-event
        evt_val   = 16'd5000;
        evt_blink = 1'b1;
        evt_req   = 1'b1;
        step(1);
        evt_req = 1'b0;
        step(10);
        check_eq("t6_pre_src", 64'(disp_src), 64'd2);
        check_eq("t6_pre_blank", 64'(disp_blank), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_val", 64'(disp_val), 64'd0);
        check_eq("t6_rst_src", 64'(disp_src), 64'd0);
        check_eq("t6_rst_blank", 64'(disp_blank), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check_eq("t6_idle_src", 64'(disp_src), 64'd0);
        check_eq("t6_idle_val", 64'(disp_val), 64'd4321);
        step(25);
        check_eq("t6_stays_idle", 64'(disp_src), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
